reg_write_sched: RTL

- Writeback controller for the 8-bit core's register-file write path.
- Accepts one decoded instruction class per cycle from decode.
- Drives the register-write input mux select (ALU result vs data-memory read data), the register write enable and address, and the data-memory read strobe.
- Stalls issue while a load is outstanding, so the shared write port never sees two writers in one cycle.

---
 rtl/wb_pkg.sv | 22 ++
 rtl/reg_write_sched.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the register-file writeback controller.
//   issue_kind_e : instruction class presented by decode on IssueKind
//   wb_state_e   : controller state encoding
//   REG_AW_DEFAULT : default register-file address width
package wb_pkg;

  localparam int unsigned REG_AW_DEFAULT = 3;

  typedef enum logic [1:0] {
    KIND_NOP   = 2'b00,
    KIND_ALU   = 2'b01,
    KIND_LOAD  = 2'b10,
    KIND_STORE = 2'b11
  } issue_kind_e;

  typedef enum logic [1:0] {
    StIdle     = 2'b00,
    StLoadReq  = 2'b01,
    StLoadWait = 2'b10
  } wb_state_e;

endpackage

// File: rtl/reg_write_sched.sv
// Writeback controller for the 8-bit core's register-file write path.
//
// Accepts one decoded instruction class per cycle. ALU results are written one
// cycle after accept; loads issue a one-cycle memory read strobe and write when
// the memory reports data valid. Issue is stalled while a load is outstanding so
// the single write port never has two writers in the same cycle.
//
// Ports:
//   CLK, Reset_n          clock (rising edge), synchronous active-low reset
//   IssueValid/Kind/Dest  decoded instruction from decode
//   IssueReady            controller accepts the issue this cycle
//   MemRdEn               one-cycle data-memory read strobe
//   MemReady              data-memory read data valid
//   RegInControl          write mux select: 1 = memory data, 0 = ALU result
//   RegWrEn, RegWrAddr    register-file write enable and address
//   LoadTimeout           sticky load timeout flag (WB_TIMEOUT_EN builds only)
//
// Build option: define WB_TIMEOUT_EN to bound LOAD_WAIT to MAX_WAIT cycles.
module reg_write_sched
  import wb_pkg::*;
#(
  parameter int unsigned REG_AW      = REG_AW_DEFAULT,
  parameter int unsigned MAX_WAIT    = 15,
  parameter int unsigned ZERO_REG_RO = 1
) (
  input  logic              CLK,
  input  logic              Reset_n,
  input  logic              IssueValid,
  input  logic [1:0]        IssueKind,
  input  logic [REG_AW-1:0] IssueDest,
  output logic              IssueReady,
  output logic              MemRdEn,
  input  logic              MemReady,
  output logic              RegInControl,
  output logic              RegWrEn,
  output logic [REG_AW-1:0] RegWrAddr
`ifdef WB_TIMEOUT_EN
  ,
  output logic              LoadTimeout
`endif
);

  wb_state_e         state_q, state_d;
  logic [REG_AW-1:0] ld_dest_q, ld_dest_d;
  logic              alu_wr_q, alu_wr_d;
  logic [REG_AW-1:0] alu_addr_q, alu_addr_d;

  logic accept;
  logic accept_alu;
  logic accept_load;
  logic ld_done;
  logic dest_blocked;
  logic ld_blocked;

`ifdef WB_TIMEOUT_EN
  localparam int unsigned CntRaw = $clog2(MAX_WAIT + 1);
  localparam int unsigned CntW   = (CntRaw < 4) ? 4 : CntRaw;

  logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
  logic            timeout_q, timeout_d;
`else
  logic unused_max_wait;
  assign unused_max_wait = (MAX_WAIT != 0);
`endif

  assign accept       = IssueValid && IssueReady;
  assign accept_alu   = accept && (IssueKind == KIND_ALU);
  assign accept_load  = accept && (IssueKind == KIND_LOAD);
  assign dest_blocked = (ZERO_REG_RO != 0) && (IssueDest == '0);
  assign ld_blocked   = (ZERO_REG_RO != 0) && (ld_dest_q == '0);

  // State register
  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      state_q    <= StIdle;
      ld_dest_q  <= '0;
      alu_wr_q   <= 1'b0;
      alu_addr_q <= '0;
`ifdef WB_TIMEOUT_EN
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      ld_dest_q  <= ld_dest_d;
      alu_wr_q   <= alu_wr_d;
      alu_addr_q <= alu_addr_d;
`ifdef WB_TIMEOUT_EN
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    ld_dest_d  = ld_dest_q;
    alu_wr_d   = accept_alu && !dest_blocked;
    alu_addr_d = accept_alu ? IssueDest : '0;
`ifdef WB_TIMEOUT_EN
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (accept_load) begin
          ld_dest_d = IssueDest;
          state_d   = StLoadReq;
        end
      end
      StLoadReq: begin
        state_d = StLoadWait;
`ifdef WB_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
      end
      StLoadWait: begin
        // MemReady takes priority over an expiring timeout
        if (MemReady) begin
          state_d = StIdle;
`ifdef WB_TIMEOUT_EN
        end else if (wait_cnt_q == CntW'(MAX_WAIT - 1)) begin
          state_d   = StIdle;
          timeout_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs; gated with Reset_n so everything reads 0 while reset is held
  always_comb begin
    IssueReady   = Reset_n && (state_q == StIdle);
    MemRdEn      = Reset_n && (state_q == StLoadReq);
    ld_done      = Reset_n && (state_q == StLoadWait) && MemReady;
    RegInControl = ld_done;
    RegWrEn      = (Reset_n && alu_wr_q) || (ld_done && !ld_blocked);
    RegWrAddr    = '0;
    if (ld_done) begin
      RegWrAddr = ld_dest_q;
    end else if (Reset_n) begin
      RegWrAddr = alu_addr_q;
    end
`ifdef WB_TIMEOUT_EN
    LoadTimeout = Reset_n && timeout_q;
`endif
  end

endmodule
